// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential ibus requests, buffers {pc, instr} in a FIFO.
// Define IFETCH_BYPASS_EN to let a returning word reach out_* in the same cycle when the FIFO is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [63:0]   fpc_q, fpc_d;
    logic          ireq_valid_q, ireq_valid_d;
    logic [63:0]   ireq_addr_q, ireq_addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic fifo_valid, push, pop, bypass_take;

    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = ireq_addr_q;
    assign fifo_valid = (count_q != '0);

`ifdef IFETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = !fifo_valid && (state_q == S_WAIT) && iresp_data_ok && !redirect_valid;
    assign bypass_take = bypass_hit && out_ready;
    assign out_valid   = fifo_valid || bypass_hit;
    assign out_pc      = fifo_valid ? mem_pc_q[rd_ptr_q]    : ireq_addr_q;
    assign out_instr   = fifo_valid ? mem_instr_q[rd_ptr_q] : iresp_data;
`else
    assign bypass_take = 1'b0;
    assign out_valid   = fifo_valid;
    assign out_pc      = mem_pc_q[rd_ptr_q];
    assign out_instr   = mem_instr_q[rd_ptr_q];
`endif

    // A redirect kills both the pop and any push in the same cycle.
    assign pop  = fifo_valid && out_ready && !redirect_valid;
    assign push = (state_q == S_WAIT) && iresp_data_ok && !redirect_valid && !bypass_take;

    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        ireq_valid_d = ireq_valid_q;
        ireq_addr_d  = ireq_addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fpc_d = redirect_pc;
                end else if (count_q < CW'(DEPTH)) begin
                    ireq_valid_d = 1'b1;
                    ireq_addr_d  = fpc_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fpc_d = redirect_pc;
                    if (iresp_data_ok) begin
                        ireq_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (iresp_data_ok) begin
                    fpc_d        = fpc_q + 64'd4;
                    ireq_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect_valid) fpc_d = redirect_pc;
                if (iresp_data_ok) begin
                    ireq_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                ireq_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fpc_q        <= RESET_PC;
            ireq_valid_q <= 1'b0;
            ireq_addr_q  <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            ireq_valid_q <= ireq_valid_d;
            ireq_addr_q  <= ireq_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc_q[wr_ptr_q]    <= ireq_addr_q;
            mem_instr_q[wr_ptr_q] <= iresp_data;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a variable-latency ibus slave, a fetch-stream reference
// model feeding a scoreboard, and a monitor that checks every cycle of out_* and ireq.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    int lat   = 1;
    int wcnt  = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;
    entry_t sb[$];

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // ibus slave: data_ok once the request has been held lat cycles (lat=1 -> same cycle).
    always @(posedge clk) begin
        if (reset || !ireq_valid || iresp_data_ok) wcnt <= 0;
        else                                       wcnt <= wcnt + 1;
    end
    assign iresp_data_ok = ireq_valid && (wcnt >= lat - 1);
    assign iresp_data    = mem_word(ireq_addr);

    // Reference model: the live fetch stream is sequential from RESET_PC or the last redirect
    // target; a request outstanding across a redirect returns a word that is thrown away.
    logic [63:0] exp_pc = RESET_PC;
    bit          stale  = 0;
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            exp_pc = RESET_PC;
            stale  = 0;
        end else if (redirect_valid) begin
            sb.delete();
            exp_pc = redirect_pc;
            stale  = ireq_valid && !iresp_data_ok;
        end else if (ireq_valid && iresp_data_ok) begin
            if (stale) begin
                stale = 0;
            end else begin
                chk("fetch_addr", ireq_addr, exp_pc);
                sb.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    // Monitor: compares the head every cycle, pops on accepted handshakes, checks bus rules.
    bit          p_rst = 1, p_valid = 0, p_dok = 0;
    logic [63:0] p_addr = '0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (out_valid && sb.size() != 0) begin
                chk("out_pc", out_pc, sb[0].pc);
                chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
                if (out_ready && !redirect_valid) begin
                    void'(sb.pop_front());
                    npop++;
                end
            end
            if (!p_rst && p_valid && !p_dok) begin
                chk("req_hold_valid", 64'(ireq_valid), 64'd1);
                chk("req_hold_addr", ireq_addr, p_addr);
            end
            if (!p_rst && p_valid && p_dok) chk("no_back_to_back", 64'(ireq_valid), 64'd0);
            if (ireq_valid && !stale) chk("issue_room", 64'(sb.size() < DEPTH), 64'd1);
        end
        p_rst   = reset;
        p_valid = ireq_valid;
        p_dok   = iresp_data_ok;
        p_addr  = ireq_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after reset has been sampled high and released.
    task automatic post_reset_checks();
        @(negedge clk);
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_ireq_addr", ireq_addr, RESET_PC);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("first_req_valid", 64'(ireq_valid), 64'd1);
        chk("first_req_addr", ireq_addr, RESET_PC);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b1;   // must be ignored while in reset
        redirect_pc    = 64'h0000_1234_0000_0000;
        out_ready      = 1'b1;
        lat            = 1;
        repeat (3) step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        post_reset_checks();

        repeat (40) step();

        // Stalled decode: FIFO fills and fetch must stop.
        out_ready = 1'b0;
        repeat (30) step();
        @(negedge clk);
        chk("full_no_issue", 64'(ireq_valid), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (20) step();

        lat = 5;
        repeat (40) step();
        lat = 1;

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                reset          = 1'b1;
                redirect_valid = 1'b0;
                repeat (2) step();
                reset = 1'b0;
                post_reset_checks();
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       redirect_pc = 64'h8000_0100;
                default: redirect_pc = {32'h0, 16'h8000, 14'($urandom), 2'b00};
            endcase
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(1, 5);
            step();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (20) step();

        total++;
        if (npop < 200) begin
            bad++;
            $display("FAIL liveness pops=%0d required>=200", npop);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
